xif_copro_result_arb: RTL and testbench

// - N-channel result arbiter/buffer between the coprocessor execution units (ALU, memory unit, ...)
//   and the core's XIF result interface.
// - Each channel pushes x_result_t into a private FIFO. The arbiter picks one non-empty FIFO per cycle
//   (round-robin or fixed priority) and loads it into a registered output stage that drives result_*.
// - Generalises the single-result path to NUM_CH channels with configurable depth and arbitration mode.

---
 rtl/xif_copro_pkg.sv | 26 ++
 rtl/xif_copro_result_fifo.sv | 59 +++++
 rtl/xif_copro_result_arb.sv | 106 ++++++++++
 tb/tb_xif_copro_result_arb.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xif_copro_pkg.sv
// Shared XIF coprocessor types: result payload, arbitration modes, default channel count.
// Pure declarations: no logic, so no latency or backpressure of its own.
package xif_copro_pkg;

  localparam int X_ID_WIDTH     = 8;
  localparam int X_RFW_WIDTH    = 32;
  localparam int NUM_CH_DEFAULT = 2;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0]  id;
    logic [X_RFW_WIDTH-1:0] data;
    logic [4:0]             rd;
    logic                   we;
    logic [2:0]             ecs;
    logic                   exc;
    logic [5:0]             exccode;
    logic                   err;
    logic                   dbg;
  } x_result_t;

endpackage

// File: rtl/xif_copro_result_fifo.sv
// Per-channel result FIFO with synchronous flush and occupancy output; head visible combinationally.
// Push accepted next edge only while not full (no push-through on simultaneous pop); ready depends on level only.
module xif_copro_result_fifo #(
  parameter int  DEPTH = 2,
  parameter type dat_t = logic [31:0],
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          push_i,
  input  dat_t          dat_i,
  output logic          ready_o,
  input  logic          pop_i,
  output dat_t          head_o,
  output logic          non_empty_o,
  output logic [LW-1:0] level_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  dat_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Depth need not be a power of two, so wrap on an explicit compare.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + AW'(1);
  endfunction

  assign ready_o     = (level_o < LW'(DEPTH));
  assign non_empty_o = (level_o != '0);
  assign do_push     = push_i && ready_o && !flush_i;
  assign do_pop      = pop_i && non_empty_o && !flush_i;
  assign head_o      = mem[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_o <= '0;
    end else if (flush_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_o <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      level_o <= level_o + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= dat_i;
  end

endmodule

// File: rtl/xif_copro_result_arb.sv
// N-channel result arbiter: per-channel FIFOs, RR or fixed-priority grant, registered XIF result stage.
// Push-to-valid 1 cycle; a presented result holds until result_ready_i, and flush never withdraws it.
module xif_copro_result_arb
  import xif_copro_pkg::*;
#(
  parameter int  NUM_CH     = NUM_CH_DEFAULT,
  parameter int  FIFO_DEPTH = 2,
  parameter int  ARB_MODE   = 0,
  parameter type result_t   = x_result_t,
  localparam int LW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic    [NUM_CH-1:0]       ch_valid_i,
  output logic    [NUM_CH-1:0]       ch_ready_o,
  input  result_t [NUM_CH-1:0]       ch_result_i,
  output logic                       result_valid_o,
  input  logic                       result_ready_i,
  output result_t                    result_o,
  output logic    [NUM_CH-1:0][LW-1:0] ch_level_o
);

  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] non_empty;
  logic [NUM_CH-1:0] pop;
  result_t           head [NUM_CH];
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     grant_idx;
  logic              grant_vld;
  logic              out_free;
  logic              load;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    xif_copro_result_fifo #(
      .DEPTH (FIFO_DEPTH),
      .dat_t (result_t)
    ) u_fifo (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .flush_i     (flush_i),
      .push_i      (ch_valid_i[c]),
      .dat_i       (ch_result_i[c]),
      .ready_o     (ch_ready_o[c]),
      .pop_i       (pop[c]),
      .head_o      (head[c]),
      .non_empty_o (non_empty[c]),
      .level_o     (ch_level_o[c])
    );
  end

  // Round-robin searches upward from ptr with wrap; fixed mode keeps the lowest index.
  always_comb begin
    int idx;
    grant_idx = '0;
    grant_vld = 1'b0;
    idx       = 0;
    if (ARB_MODE == int'(ARB_FIXED)) begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (non_empty[i]) begin
          grant_idx = PW'(i);
          grant_vld = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        idx = int'(ptr) + i;
        if (idx >= NUM_CH) idx = idx - NUM_CH;
        if (!grant_vld && non_empty[PW'(idx)]) begin
          grant_idx = PW'(idx);
          grant_vld = 1'b1;
        end
      end
    end
  end

  assign out_free = !result_valid_o || result_ready_i;
  assign load     = out_free && grant_vld && !flush_i;

  always_comb begin
    pop = '0;
    if (load) pop[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      result_valid_o <= 1'b0;
      result_o       <= '0;
    end else if (out_free) begin
      result_valid_o <= load;
      if (load) result_o <= head[grant_idx];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr <= '0;
    end else if (flush_i) begin
      ptr <= '0;
    end else if (load && (ARB_MODE == int'(ARB_RR))) begin
      ptr <= (int'(grant_idx) == NUM_CH - 1) ? '0 : grant_idx + PW'(1);
    end
  end

endmodule

// File: tb/tb_xif_copro_result_arb.sv
// Directed bench: three arbiter instances (RR depth 2, fixed depth 2, RR depth 3) with hand-derived results.
module tb_xif_copro_result_arb;
  import xif_copro_pkg::*;

  localparam int DEP [3] = '{2, 2, 3};

  logic                 clk;
  logic                 rst_n;
  logic                 flush;
  logic [1:0]           cv   [3];
  logic [1:0]           crdy [3];
  x_result_t [1:0]      cr   [3];
  logic                 vld  [3];
  logic                 rr   [3];
  x_result_t            res  [3];
  logic [1:0][1:0]      lvl  [3];

  int        vectors;
  int        miscompares;
  x_result_t got [$];

  xif_copro_result_arb #(.NUM_CH(2), .FIFO_DEPTH(2), .ARB_MODE(0)) u_dut_rr (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .ch_valid_i(cv[0]), .ch_ready_o(crdy[0]), .ch_result_i(cr[0]),
    .result_valid_o(vld[0]), .result_ready_i(rr[0]), .result_o(res[0]), .ch_level_o(lvl[0]));

  xif_copro_result_arb #(.NUM_CH(2), .FIFO_DEPTH(2), .ARB_MODE(1)) u_dut_fix (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .ch_valid_i(cv[1]), .ch_ready_o(crdy[1]), .ch_result_i(cr[1]),
    .result_valid_o(vld[1]), .result_ready_i(rr[1]), .result_o(res[1]), .ch_level_o(lvl[1]));

  xif_copro_result_arb #(.NUM_CH(2), .FIFO_DEPTH(3), .ARB_MODE(0)) u_dut_d3 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .ch_valid_i(cv[2]), .ch_ready_o(crdy[2]), .ch_result_i(cr[2]),
    .result_valid_o(vld[2]), .result_ready_i(rr[2]), .result_o(res[2]), .ch_level_o(lvl[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic x_result_t mk(input int id);
    x_result_t r;
    r      = '0;
    r.id   = X_ID_WIDTH'(id);
    r.data = 32'hC0DE_0000 | 32'(id);
    r.rd   = 5'(id);
    r.we   = 1'b1;
    return r;
  endfunction

  task automatic reset_all();
    rst_n = 1'b0;
    flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cv[k] = '0;
      cr[k] = '0;
      rr[k] = 1'b0;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Handshaked producer/consumer loop on instance k; accepted results collected into got.
  task automatic stream(input int k, input int n0, input int n1, input int b1,
                        input int hold, input int tog, input int bp);
    int        sent [2];
    int        cyc;
    logic      prev_stall;
    x_result_t prev_res;
    sent[0] = 0; sent[1] = 0; cyc = 0; prev_stall = 1'b0; prev_res = '0;
    got.delete();
    while (1) begin
      for (int c = 0; c < 2; c++) begin
        cv[k][c] = (sent[c] < ((c == 0) ? n0 : n1));
        cr[k][c] = mk((c == 0) ? sent[0] : b1 + sent[1]);
      end
      rr[k] = (cyc >= hold) && ((tog == 0) || (cyc % 2 == 1));
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
        vectors++;
        if (crdy[k][c] !== (int'(lvl[k][c]) < DEP[k])) begin
          miscompares++;
          $display("FAIL ready_vs_level inst%0d ch%0d cyc%0d: ready=%b level=%0d", k, c, cyc, crdy[k][c], lvl[k][c]);
        end
      end
      if (prev_stall && vld[k]) begin
        vectors++;
        if (res[k] !== prev_res) begin
          miscompares++;
          $display("FAIL stable inst%0d cyc%0d: got %h want %h", k, cyc, res[k], prev_res);
        end
      end
      if (bp != 0 && cyc == hold - 1) begin
        vectors++;
        if (crdy[k] !== 2'b00 || lvl[k][0] !== 2'd2 || lvl[k][1] !== 2'd2 ||
            vld[k] !== 1'b1 || res[k] !== mk(0) || sent[0] != 3 || sent[1] != 2 || cv[k] !== 2'b11) begin
          miscompares++;
          $display("FAIL bp_full: ready=%b lvl0=%0d lvl1=%0d vld=%b id=%0d sent=%0d/%0d want ready=00 lvl=2/2 vld=1 id=0 sent=3/2",
                   crdy[k], lvl[k][0], lvl[k][1], vld[k], res[k].id, sent[0], sent[1]);
        end
      end
      prev_stall = vld[k] && !rr[k];
      prev_res   = res[k];
      if (vld[k] && rr[k]) got.push_back(res[k]);
      for (int c = 0; c < 2; c++)
        if (cv[k][c] && crdy[k][c]) sent[c]++;
      @(posedge clk); #1;
      cyc++;
      if (sent[0] == n0 && sent[1] == n1 && !vld[k] && lvl[k] == '0) break;
      if (cyc > 400) begin
        vectors++;
        miscompares++;
        $display("FAIL stream_timeout inst%0d: sent=%0d/%0d got=%0d", k, sent[0], sent[1], got.size());
        break;
      end
    end
    cv[k] = '0;
    rr[k] = 1'b0;
  endtask

  task automatic test_reset();
    reset_all();
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (vld[k] !== 1'b0 || res[k] !== '0 || crdy[k] !== 2'b11 || lvl[k] !== '0) begin
        miscompares++;
        $display("FAIL reset_state inst%0d: vld=%b res=%h ready=%b lvl=%h", k, vld[k], res[k], crdy[k], lvl[k]);
      end
    end
    cv[0] = 2'b11; cr[0][0] = mk(1); cr[0][1] = mk(2);
    @(posedge clk); #1;
    cr[0][0] = mk(3); cr[0][1] = mk(4);
    @(posedge clk); #1;
    cv[0] = 2'b00;
    vectors++;
    if (vld[0] !== 1'b1 || res[0] !== mk(1) || lvl[0][0] !== 2'd1 || lvl[0][1] !== 2'd2) begin
      miscompares++;
      $display("FAIL pre_reset: vld=%b id=%0d lvl0=%0d lvl1=%0d want 1/1/1/2", vld[0], res[0].id, lvl[0][0], lvl[0][1]);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (vld[0] !== 1'b0 || crdy[0] !== 2'b11 || lvl[0] !== '0 || res[0] !== '0) begin
      miscompares++;
      $display("FAIL async_reset: vld=%b ready=%b lvl=%h res=%h want 0/11/0/0", vld[0], crdy[0], lvl[0], res[0]);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single_push();
    reset_all();
    rr[0] = 1'b1;
    cv[0] = 2'b01;
    cr[0][0] = mk(3);
    cr[0][0].data = 32'hDEADBEEF;
    @(posedge clk); #1;
    cv[0] = 2'b00;
    vectors++;
    if (vld[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL single_t0: vld=%b want 0", vld[0]);
    end
    @(posedge clk); #1;
    vectors++;
    if (vld[0] !== 1'b1 || res[0].id !== 8'd3 || res[0].data !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL single_t1: vld=%b id=%0d data=%h want 1/3/deadbeef", vld[0], res[0].id, res[0].data);
    end
    @(posedge clk); #1;
    vectors++;
    if (vld[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL single_t2: vld=%b want 0", vld[0]);
    end
    rr[0] = 1'b0;
  endtask

  task automatic test_arb_order();
    int exp_rr  [8] = '{0, 8, 1, 9, 2, 10, 3, 11};
    int exp_fix [8] = '{0, 1, 2, 3, 8, 9, 10, 11};
    reset_all();
    stream(0, 4, 4, 8, 0, 0, 0);
    vectors++;
    if (got.size() != 8) begin
      miscompares++;
      $display("FAIL rr_count: got %0d want 8", got.size());
    end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      vectors++;
      if (got[i] !== mk(exp_rr[i])) begin
        miscompares++;
        $display("FAIL rr_order[%0d]: got id %0d want %0d", i, got[i].id, exp_rr[i]);
      end
    end
    reset_all();
    stream(1, 4, 4, 8, 0, 0, 0);
    vectors++;
    if (got.size() != 8) begin
      miscompares++;
      $display("FAIL fix_count: got %0d want 8", got.size());
    end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      vectors++;
      if (got[i] !== mk(exp_fix[i])) begin
        miscompares++;
        $display("FAIL fix_order[%0d]: got id %0d want %0d", i, got[i].id, exp_fix[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int n0c;
    int n1c;
    n0c = 0; n1c = 0;
    reset_all();
    stream(0, 4, 4, 8, 10, 0, 1);
    foreach (got[i]) begin
      vectors++;
      if (got[i].id < 8) begin
        if (got[i] !== mk(n0c)) begin
          miscompares++;
          $display("FAIL bp_ch0_order: got id %0d want %0d", got[i].id, n0c);
        end
        n0c++;
      end else begin
        if (got[i] !== mk(8 + n1c)) begin
          miscompares++;
          $display("FAIL bp_ch1_order: got id %0d want %0d", got[i].id, 8 + n1c);
        end
        n1c++;
      end
    end
    vectors++;
    if (n0c != 4 || n1c != 4) begin
      miscompares++;
      $display("FAIL bp_drain: ch0 %0d ch1 %0d results, want 4 and 4", n0c, n1c);
    end
  endtask

  task automatic test_flush();
    reset_all();
    cv[0] = 2'b10;
    cr[0][1] = mk(5);
    @(posedge clk); #1;
    cr[0][1] = mk(6);
    @(posedge clk); #1;
    cr[0][1] = mk(7);
    @(posedge clk); #1;
    cv[0] = 2'b00;
    vectors++;
    if (vld[0] !== 1'b1 || res[0] !== mk(5) || lvl[0][1] !== 2'd2) begin
      miscompares++;
      $display("FAIL flush_setup: vld=%b id=%0d lvl1=%0d want 1/5/2", vld[0], res[0].id, lvl[0][1]);
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    vectors++;
    if (vld[0] !== 1'b1 || res[0] !== mk(5) || lvl[0] !== '0 || crdy[0] !== 2'b11) begin
      miscompares++;
      $display("FAIL flush_hold: vld=%b id=%0d lvl=%h ready=%b want 1/5/0/11", vld[0], res[0].id, lvl[0], crdy[0]);
    end
    rr[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (vld[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL flush_after[%0d]: vld=%b id=%0d want 0", i, vld[0], res[0].id);
      end
    end
    rr[0] = 1'b0;
  endtask

  task automatic test_wrap();
    reset_all();
    stream(2, 20, 0, 8, 0, 1, 0);
    vectors++;
    if (got.size() != 20) begin
      miscompares++;
      $display("FAIL wrap_count: got %0d want 20", got.size());
    end
    for (int i = 0; i < 20 && i < got.size(); i++) begin
      vectors++;
      if (got[i] !== mk(i)) begin
        miscompares++;
        $display("FAIL wrap_order[%0d]: got id %0d want %0d", i, got[i].id, i);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    flush       = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cv[k] = '0;
      cr[k] = '0;
      rr[k] = 1'b0;
    end
    test_reset();
    test_single_push();
    test_arb_order();
    test_backpressure();
    test_flush();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
